// File: rtl/trap_pkg.sv
// Shared definitions for the trapezoidal shaper.
//   LAT          : input-accept to out_valid latency in cycles
//   trap_state_e : control FSM states (run, drain pipeline, clear datapath)
//   acc_width()  : signed accumulator width that cannot wrap for legal k, l, M
//   sat_to()     : clip a signed value into a signed w-bit range
package trap_pkg;

   localparam int unsigned LAT = 4;

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StClear
   } trap_state_e;

   function automatic int unsigned acc_width(input int unsigned adc_w,
                                             input int unsigned m_w,
                                             input int unsigned max_depth);
      return adc_w + m_w + 2 * int'($clog2(max_depth)) + 4;
   endfunction

   // Result stays 64 bits wide; the caller takes the low w bits, and compares
   // the result with the input to detect clipping.
   function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                 input int unsigned       w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/trap_peak_hold.sv
// Peak-hold tracker on the shaped output stream.
// Tracks the maximum of data_i while it is above PEAK_THR; on the first valid
// sample at or below PEAK_THR after at least one above it, pulses peak_valid_o
// for one cycle with peak_data_o holding that maximum, then re-arms.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   clear_i       : synchronous clear of the tracker
//   valid_i       : data_i qualifier
//   data_i        : signed shaped sample
//   peak_valid_o  : one-cycle peak strobe
//   peak_data_o   : peak value of the last completed pulse
module trap_peak_hold #(
   parameter int unsigned             OUT_W    = 16,
   parameter logic signed [OUT_W-1:0] PEAK_THR = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_i,
   input  logic                    valid_i,
   input  logic signed [OUT_W-1:0] data_i,
   output logic                    peak_valid_o,
   output logic signed [OUT_W-1:0] peak_data_o
);

   logic                    armed_q, armed_d;
   logic signed [OUT_W-1:0] max_q, max_d;
   logic                    pv_q, pv_d;
   logic signed [OUT_W-1:0] pd_q, pd_d;

   always_comb begin
      armed_d = armed_q;
      max_d   = max_q;
      pv_d    = 1'b0;
      pd_d    = pd_q;
      if (clear_i) begin
         armed_d = 1'b0;
         max_d   = '0;
         pd_d    = '0;
      end else if (valid_i) begin
         if (data_i > PEAK_THR) begin
            armed_d = 1'b1;
            // First sample above threshold starts a fresh maximum.
            if (!armed_q || data_i > max_q) begin
               max_d = data_i;
            end
         end else if (armed_q) begin
            pv_d    = 1'b1;
            pd_d    = max_q;
            armed_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         armed_q <= 1'b0;
         max_q   <= '0;
         pv_q    <= 1'b0;
         pd_q    <= '0;
      end else begin
         armed_q <= armed_d;
         max_q   <= max_d;
         pv_q    <= pv_d;
         pd_q    <= pd_d;
      end
   end

   assign peak_valid_o = pv_q;
   assign peak_data_o  = pd_q;

endmodule

// File: rtl/trap_shaper_cfg.sv
// Runtime-configurable trapezoidal shaper with pole-zero correction.
//   d = x[n] - x[n-k] - x[n-l] + x[n-k-l];  p += d;  r = p + M*d;  s += r;
//   y = sat(s >>> SHIFT)
// New k, l, M are loaded through a drain/clear handshake: a legal request
// stalls input, lets in-flight samples finish, clears the datapath and then
// switches to the new configuration.
// Optional feature: define TRAP_PEAK_HOLD_EN to enable the peak-hold tracker;
// otherwise peak_valid_o / peak_data_o are tied to zero.
// Ports:
//   clk, reset             : clock, synchronous active-low reset
//   in_valid_i/in_ready_o  : sample handshake, in_data_i unsigned ADC sample
//   cfg_load_i, cfg_k_i, cfg_l_i, cfg_m_i : configuration request
//   cfg_err_o              : one-cycle pulse on a rejected request
//   out_valid_o, out_data_o, out_sat_o    : shaped output and clip flag
//   peak_valid_o, peak_data_o             : peak-hold result
module trap_shaper_cfg
   import trap_pkg::*;
#(
   parameter int unsigned             ADC_W     = 12,
   parameter int unsigned             OUT_W     = 16,
   parameter int unsigned             MAX_DEPTH = 64,
   parameter int unsigned             M_W       = 8,
   parameter int unsigned             SHIFT     = 7,
   parameter int unsigned             K_DEF     = 2,
   parameter int unsigned             L_DEF     = 4,
   parameter int unsigned             M_DEF     = 0,
   parameter logic signed [OUT_W-1:0] PEAK_THR  = '0,
   localparam int unsigned            CFG_W     = $clog2(MAX_DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [ADC_W-1:0]        in_data_i,
   input  logic                    cfg_load_i,
   input  logic [CFG_W-1:0]        cfg_k_i,
   input  logic [CFG_W-1:0]        cfg_l_i,
   input  logic [M_W-1:0]          cfg_m_i,
   output logic                    cfg_err_o,
   output logic                    out_valid_o,
   output logic signed [OUT_W-1:0] out_data_o,
   output logic                    out_sat_o,
   output logic                    peak_valid_o,
   output logic signed [OUT_W-1:0] peak_data_o
);

   localparam int unsigned ACC_W = acc_width(ADC_W, M_W, MAX_DEPTH);
   localparam int unsigned IDX_W = $clog2(MAX_DEPTH);

   typedef logic signed [ACC_W-1:0] acc_t;

   // Control
   trap_state_e      state_q, state_d;
   logic [CFG_W-1:0] k_q, l_q, ks_q, ls_q;
   logic [M_W-1:0]   m_q, ms_q;
   logic             err_q, err_d;
   logic             shadow_load, legal, accept, clear;

   // Datapath
   logic [ADC_W-1:0]        line_q [MAX_DEPTH];
   logic                    v1_q, v2_q, v3_q, v4_q;
   acc_t                    d1_q, p_q, md_q, r_q, s_q;
   logic signed [OUT_W-1:0] y_q;
   logic                    sat_q;

   logic [IDX_W-1:0]   k_idx, l_idx, kl_idx;
   acc_t               x_new, x_k, x_l, x_kl, d_new, m_ext, s_sum, s_shr;
   logic signed [63:0] s_wide, y_wide;

   assign in_ready_o = (state_q == StRun);
   assign accept     = in_valid_i & in_ready_o;
   assign clear      = (state_q == StClear);
   assign legal      = (cfg_k_i != '0) && (cfg_k_i <= cfg_l_i) &&
                       (({1'b0, cfg_k_i} + {1'b0, cfg_l_i}) <= (CFG_W + 1)'(MAX_DEPTH));

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d     = state_q;
      shadow_load = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         StRun: begin
            if (cfg_load_i) begin
               if (legal) begin
                  shadow_load = 1'b1;
                  state_d     = StDrain;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         // Input is stalled, so stages 1-3 empty within LAT-1 cycles; the
         // sample in the output register has already been presented.
         StDrain: begin
            if (!(v1_q || v2_q || v3_q)) begin
               state_d = StClear;
            end
         end
         StClear: state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StRun;
         err_q   <= 1'b0;
         k_q     <= CFG_W'(K_DEF);
         l_q     <= CFG_W'(L_DEF);
         m_q     <= M_W'(M_DEF);
         ks_q    <= CFG_W'(K_DEF);
         ls_q    <= CFG_W'(L_DEF);
         ms_q    <= M_W'(M_DEF);
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (shadow_load) begin
            ks_q <= cfg_k_i;
            ls_q <= cfg_l_i;
            ms_q <= cfg_m_i;
         end
         if (clear) begin
            k_q <= ks_q;
            l_q <= ls_q;
            m_q <= ms_q;
         end
      end
   end

   // ------------------------------------------------------- arithmetic
   // line_q[i] holds x[n-1-i], so the tap for x[n-j] is line_q[j-1].
   // Legal k, l keep every index below MAX_DEPTH.
   assign k_idx  = IDX_W'(k_q - CFG_W'(1));
   assign l_idx  = IDX_W'(l_q - CFG_W'(1));
   assign kl_idx = IDX_W'(k_q + l_q - CFG_W'(1));

   assign x_new = $signed({{(ACC_W - ADC_W){1'b0}}, in_data_i});
   assign x_k   = $signed({{(ACC_W - ADC_W){1'b0}}, line_q[k_idx]});
   assign x_l   = $signed({{(ACC_W - ADC_W){1'b0}}, line_q[l_idx]});
   assign x_kl  = $signed({{(ACC_W - ADC_W){1'b0}}, line_q[kl_idx]});
   assign d_new = x_new - x_k - x_l + x_kl;

   assign m_ext  = $signed({{(ACC_W - M_W){1'b0}}, m_q});
   assign s_sum  = s_q + r_q;
   assign s_shr  = s_sum >>> SHIFT;
   assign s_wide = 64'(s_shr);
   assign y_wide = sat_to(s_wide, OUT_W);

   // Stage 1: d. Stage 2: p and M*d from the same d. Stage 3: r. Stage 4: s, y.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         for (int i = 0; i < int'(MAX_DEPTH); i++) begin
            line_q[i] <= '0;
         end
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         v4_q  <= 1'b0;
         d1_q  <= '0;
         p_q   <= '0;
         md_q  <= '0;
         r_q   <= '0;
         s_q   <= '0;
         y_q   <= '0;
         sat_q <= 1'b0;
      end else begin
         if (accept) begin
            line_q[0] <= in_data_i;
            for (int i = 1; i < int'(MAX_DEPTH); i++) begin
               line_q[i] <= line_q[i-1];
            end
            d1_q <= d_new;
         end
         v1_q <= accept;
         v2_q <= v1_q;
         v3_q <= v2_q;
         v4_q <= v3_q;
         if (v1_q) begin
            p_q  <= p_q + d1_q;
            md_q <= d1_q * m_ext;
         end
         if (v2_q) begin
            r_q <= p_q + md_q;
         end
         if (v3_q) begin
            s_q   <= s_sum;
            y_q   <= y_wide[OUT_W-1:0];
            sat_q <= (y_wide != s_wide);
         end
      end
   end

   assign cfg_err_o   = err_q;
   assign out_valid_o = v4_q;
   assign out_data_o  = y_q;
   assign out_sat_o   = sat_q;

`ifdef TRAP_PEAK_HOLD_EN
   trap_peak_hold #(
      .OUT_W    (OUT_W),
      .PEAK_THR (PEAK_THR)
   ) u_peak_hold (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (clear),
      .valid_i      (v4_q),
      .data_i       (y_q),
      .peak_valid_o (peak_valid_o),
      .peak_data_o  (peak_data_o)
   );
`else
   logic unused_peak_thr;
   assign unused_peak_thr = ^PEAK_THR;
   assign peak_valid_o    = 1'b0;
   assign peak_data_o     = '0;
`endif

endmodule

// File: tb/tb_trap_shaper_cfg.sv
// Directed self-checking bench for trap_shaper_cfg (SHIFT=0, PEAK_THR=50).
// Expected outputs are hand-derived from the d/p/r/s recurrences.
module tb_trap_shaper_cfg;

   localparam int unsigned OUT_W = 16;
   localparam int unsigned CFG_W = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    reset;
   logic                    in_valid, in_ready;
   logic [11:0]             in_data;
   logic                    cfg_load, cfg_err;
   logic [CFG_W-1:0]        cfg_k, cfg_l;
   logic [7:0]              cfg_m;
   logic                    out_valid, out_sat, peak_valid;
   logic signed [OUT_W-1:0] out_data, peak_data;

   int n_cmp = 0;
   int n_mis = 0;
   int cap_d[$];
   int cap_s[$];
   int pk_q[$];
   int exp_d[$];
   int exp_s[$];

   trap_shaper_cfg #(
      .SHIFT    (0),
      .PEAK_THR (16'sd50)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .cfg_load_i   (cfg_load),
      .cfg_k_i      (cfg_k),
      .cfg_l_i      (cfg_l),
      .cfg_m_i      (cfg_m),
      .cfg_err_o    (cfg_err),
      .out_valid_o  (out_valid),
      .out_data_o   (out_data),
      .out_sat_o    (out_sat),
      .peak_valid_o (peak_valid),
      .peak_data_o  (peak_data)
   );

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         cap_d.push_back(int'(out_data));
         cap_s.push_back(int'(out_sat));
      end
      if (peak_valid === 1'b1) begin
         pk_q.push_back(int'(peak_data));
      end
   end

   task automatic check_val(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_seq(input string tag);
      logic signed [63:0] g;
      check_val({tag, "_count"}, 64'(cap_d.size()), 64'(exp_d.size()));
      for (int i = 0; i < exp_d.size(); i++) begin
         g = 'x;
         if (i < cap_d.size()) g = 64'(cap_d[i]);
         check_val($sformatf("%s_y%0d", tag, i), g, 64'(exp_d[i]));
      end
      for (int i = 0; i < exp_s.size(); i++) begin
         g = 'x;
         if (i < cap_s.size()) g = 64'(cap_s[i]);
         check_val($sformatf("%s_sat%0d", tag, i), g, 64'(exp_s[i]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      in_valid = 1'b1;
      in_data  = 12'(v);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic clr();
      cap_d.delete();
      cap_s.delete();
      pk_q.delete();
   endtask

   task automatic set_cfg(input int k, input int l, input int m);
      cfg_k = CFG_W'(k);
      cfg_l = CFG_W'(l);
      cfg_m = 8'(m);
   endtask

   task automatic load_cfg(input int k, input int l, input int m, input string tag);
      int w;
      cfg_load = 1'b1;
      set_cfg(k, l, m);
      tick();
      cfg_load = 1'b0;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      check_val({tag, "_ready"}, 64'(in_ready), 64'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check_val({tag, "_out_data"}, 64'(out_data), 64'd0);
      check_val({tag, "_out_sat"}, 64'(out_sat), 64'd0);
      check_val({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
      check_val({tag, "_peak_valid"}, 64'(peak_valid), 64'd0);
      check_val({tag, "_peak_data"}, 64'(peak_data), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      int ill_k[3];
      int ill_l[3];
      ill_k = '{5, 40, 0};
      ill_l = '{3, 30, 4};

      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      cfg_load = 1'b0;
      set_cfg(0, 0, 0);
      tick();
      tick();
      check_idle_outputs("rst");
      reset = 1'b1;
      tick();

      // Step 0 -> 100, defaults k=2 l=4 M=0: y = running sum of p.
      clr();
      send(0);
      send(0);
      repeat (8) send(100);
      repeat (6) tick();
      exp_d = '{0, 0, 100, 300, 500, 700, 800, 800, 800, 800};
      exp_s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      check_seq("step");

      // Impulse 64 with M=3.
      load_cfg(2, 4, 3, "ld_m3");
      clr();
      send(64);
      repeat (8) send(0);
      repeat (6) tick();
      exp_d = '{256, 320, 128, 128, -128, -192, 0, 0, 0};
      exp_s = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      check_seq("imp_m3");
`ifdef TRAP_PEAK_HOLD_EN
      check_val("peak_count", 64'(pk_q.size()), 64'd1);
      check_val("peak_data", (pk_q.size() > 0) ? 64'(pk_q[0]) : 64'bx, 64'd320);
`else
      check_val("peak_off_count", 64'(pk_q.size()), 64'd0);
`endif

      // Illegal requests interleaved with the same impulse stream.
      clr();
      for (int i = 0; i < 9; i++) begin
         if (i % 2 == 0 && i / 2 < 3) begin
            cfg_load = 1'b1;
            set_cfg(ill_k[i/2], ill_l[i/2], 7);
         end
         send((i == 0) ? 64 : 0);
         check_val($sformatf("ill_err%0d", i), 64'(cfg_err),
                   64'(cfg_load ? 1 : 0));
         check_val($sformatf("ill_ready%0d", i), 64'(in_ready), 64'd1);
         cfg_load = 1'b0;
      end
      repeat (6) tick();
      exp_d = '{256, 320, 128, 128, -128, -192, 0, 0, 0};
      exp_s = '{};
      check_seq("ill_keep");

      // Legal load mid-stream; the sample sent with it uses the old config.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      clr();
      repeat (3) send(0);
      cfg_load = 1'b1;
      set_cfg(1, 3, 0);
      send(20);
      cfg_load = 1'b0;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      // w counts cycles after the load cycle; load-to-ready must be <= LAT+2.
      check_val("mid_ready_time", 64'((w >= 1 && w <= 5) ? 1 : 0), 64'd1);
      tick();
      exp_d = '{0, 0, 0, 20};
      exp_s = '{};
      check_seq("pre_load");
      clr();
      send(10);
      repeat (6) send(0);
      repeat (6) tick();
      exp_d = '{10, 10, 10, 0, 0, 0, 0};
      exp_s = '{};
      check_seq("post_load");

      // Full-scale step with M=255: clips high, then settles at 32760.
      load_cfg(2, 4, 255, "ld_sat");
      clr();
      repeat (8) send(4095);
      repeat (6) tick();
      exp_d = '{32767, 32767, 32767, 32767, 32767, 32760, 32760, 32760};
      exp_s = '{1, 1, 1, 1, 1, 0, 0, 0};
      check_seq("sat");

      // Reset during DRAIN with samples in flight.
      repeat (2) send(50);
      cfg_load = 1'b1;
      set_cfg(3, 3, 1);
      send(50);
      cfg_load = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      check_idle_outputs("drain_rst");
      reset = 1'b1;
      clr();
      in_valid = 1'b1;
      in_data  = 12'd64;
      tick();
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 10) begin
         tick();
         w++;
      end
      // out_valid appears LAT cycles after the accept cycle.
      check_val("latency", 64'(w), 64'd3);
      repeat (7) send(0);
      repeat (6) tick();
      exp_d = '{64, 128, 128, 128, 64, 0, 0, 0};
      exp_s = '{0, 0, 0, 0, 0, 0, 0, 0};
      check_seq("dflt_after_rst");
`ifdef TRAP_PEAK_HOLD_EN
      check_val("peak2_count", 64'(pk_q.size()), 64'd1);
      check_val("peak2_data", (pk_q.size() > 0) ? 64'(pk_q[0]) : 64'bx, 64'd128);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
